pulse_train_ctrl: RTL and testbench

Programmable controller that sequences a pulse-generation output. It produces a train of N pulses with configurable high width and period. Start/stop/done handshake lets a host or sequencer FSM launch, abort and observe pulse bursts. It replaces fixed-ratio ring-counter pulse sources where period and duty must be set at run time.

---
 rtl/pulse_train_ctrl.sv | 141 ++++++++++++++
 tb/tb_pulse_train_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_ctrl.sv
// Programmable pulse-train controller: emits num pulses of a given width and period with start/stop/done handshake.
// Optional continuous mode (num=0 repeats until stop) is enabled by defining PULSE_TRAIN_CTRL_CONT_EN.
module pulse_train_ctrl #(
    parameter int CNT_W = 8,
    parameter int NUM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic [NUM_W-1:0] num_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic [NUM_W-1:0] pulse_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [NUM_W-1:0] NUM_ONE = 1;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] width_q;
    logic [NUM_W-1:0] num_q;
    logic [CNT_W-1:0] phase;

    logic cfg_ok;
    logic num_ok;
    logic last_pulse;
    logic load_cfg;
    logic cfg_reject;
    logic next_pulse;

`ifdef PULSE_TRAIN_CTRL_CONT_EN
    logic cont_q;

    // num=0 selects an endless train; the index simply wraps.
    assign num_ok     = 1'b1;
    assign last_pulse = !cont_q && (pulse_idx_o == num_q - NUM_ONE);
`else
    assign num_ok     = (num_i != '0);
    assign last_pulse = (pulse_idx_o == num_q - NUM_ONE);
`endif

    assign cfg_ok = (width_i != '0) && (period_i > width_i) && num_ok;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load_cfg   = 1'b0;
        cfg_reject = 1'b0;
        next_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !stop_i) begin
                    if (cfg_ok) begin
                        state_next = S_HIGH;
                        load_cfg   = 1'b1;
                    end else begin
                        cfg_reject = 1'b1;
                    end
                end
            end
            S_HIGH: begin
                if (stop_i) begin
                    state_next = S_DONE;
                end else if (phase == width_q - CNT_ONE) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (stop_i) begin
                    state_next = S_DONE;
                end else if (phase == period_q - CNT_ONE) begin
                    if (last_pulse) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_HIGH;
                        next_pulse = 1'b1;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            period_q    <= '0;
            width_q     <= '0;
            num_q       <= '0;
            phase       <= '0;
            pulse_o     <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            cfg_err_o   <= 1'b0;
            pulse_idx_o <= '0;
`ifdef PULSE_TRAIN_CTRL_CONT_EN
            cont_q      <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            // Outputs are decoded from the next state so they line up with the state register.
            pulse_o   <= (state_next == S_HIGH);
            busy_o    <= (state_next == S_HIGH) || (state_next == S_LOW);
            done_o    <= (state_next == S_DONE);
            cfg_err_o <= cfg_reject;

            if (load_cfg) begin
                period_q    <= period_i;
                width_q     <= width_i;
                num_q       <= num_i;
                phase       <= '0;
                pulse_idx_o <= '0;
`ifdef PULSE_TRAIN_CTRL_CONT_EN
                cont_q      <= (num_i == '0);
`endif
            end else if (next_pulse) begin
                phase       <= '0;
                pulse_idx_o <= pulse_idx_o + NUM_ONE;
            end else if (state == S_HIGH || state == S_LOW) begin
                phase <= phase + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pulse_train_ctrl.sv
// Self-checking bench for pulse_train_ctrl: table of bursts plus hand-written abort/collision/reset sequences.
module tb_pulse_train_ctrl;

    localparam int CNT_W = 8;
    localparam int NUM_W = 8;

    logic             clk;
    logic             rst;
    logic             start_i;
    logic             stop_i;
    logic [CNT_W-1:0] period_i;
    logic [CNT_W-1:0] width_i;
    logic [NUM_W-1:0] num_i;
    logic             pulse_o;
    logic             busy_o;
    logic             done_o;
    logic             cfg_err_o;
    logic [NUM_W-1:0] pulse_idx_o;

    pulse_train_ctrl #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .stop_i     (stop_i),
        .period_i   (period_i),
        .width_i    (width_i),
        .num_i      (num_i),
        .pulse_o    (pulse_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .cfg_err_o  (cfg_err_o),
        .pulse_idx_o(pulse_idx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             pulse;
        logic             busy;
        logic             done;
        logic             err;
        logic [NUM_W-1:0] idx;
    } obs_t;

    // One burst request and the hand-derived outcome: error strobe, cycle of the done strobe, final index.
    typedef struct {
        string name;
        int    period;
        int    width;
        int    num;
        int    stop_at;
        bit    start_mid;
        bit    exp_err;
        int    exp_done;
        int    exp_idx;
    } vec_t;

    obs_t sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   last_idx = 0;

    function automatic obs_t mk(input logic p, input logic b, input logic d, input logic e, input int idx);
        obs_t o;
        o.pulse = p;
        o.busy  = b;
        o.done  = d;
        o.err   = e;
        o.idx   = NUM_W'(idx);
        return o;
    endfunction

    task automatic check(input string name, input int cyc, input obs_t got, input obs_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got pulse=%b busy=%b done=%b err=%b idx=%0d, expected pulse=%b busy=%b done=%b err=%b idx=%0d",
                     name, cyc, got.pulse, got.busy, got.done, got.err, got.idx,
                     exp.pulse, exp.busy, exp.done, exp.err, exp.idx);
        end
    endtask

    task automatic pop_check(input string name, input int cyc);
        obs_t got;
        obs_t exp;
        got = {pulse_o, busy_o, done_o, cfg_err_o, pulse_idx_o};
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s cycle %0d: scoreboard empty", name, cyc);
        end else begin
            exp = sb.pop_front();
            check(name, cyc, got, exp);
        end
    endtask

    task automatic drive_cfg(input int p, input int w, input int n);
        period_i = CNT_W'(p);
        width_i  = CNT_W'(w);
        num_i    = NUM_W'(n);
    endtask

    // Called at a negedge with the DUT idle; start is sampled at the following posedge (cycle T).
    task automatic run_vec(input vec_t v);
        int n;
        start_i = 1'b1;
        stop_i  = 1'b0;
        drive_cfg(v.period, v.width, v.num);
        if (v.exp_err) begin
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, last_idx));
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, last_idx));
        end else begin
            for (int k = 1; k < v.exp_done; k++)
                sb.push_back(mk(((k - 1) % v.period) < v.width, 1'b1, 1'b0, 1'b0, (k - 1) / v.period));
            sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, v.exp_idx));
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, v.exp_idx));
            last_idx = v.exp_idx;
        end
        n = sb.size();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            pop_check(v.name, k);
            if (k < n) begin
                start_i = v.start_mid;
                stop_i  = (k == v.stop_at);
                drive_cfg($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            end else begin
                start_i = 1'b0;
                stop_i  = 1'b0;
            end
        end
    endtask

    task automatic add_vec(input string name, input int p, input int w, input int n, input int stop_at,
                           input bit start_mid, input bit exp_err, input int exp_done, input int exp_idx);
        vec_t v;
        v.name      = name;
        v.period    = p;
        v.width     = w;
        v.num       = n;
        v.stop_at   = stop_at;
        v.start_mid = start_mid;
        v.exp_err   = exp_err;
        v.exp_done  = exp_done;
        v.exp_idx   = exp_idx;
        vecs.push_back(v);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        stop_i  = 1'b0;
        drive_cfg(0, 0, 0);

        //       name          per  wid num stop mid err done idx
        add_vec("basic",        4,   1,  3,  0,   0,  0,  13,  2);
        add_vec("err_width0",   4,   0,  3,  0,   0,  1,   0,  0);
        add_vec("err_per_eq_w", 3,   3,  2,  0,   0,  1,   0,  0);
`ifndef PULSE_TRAIN_CTRL_CONT_EN
        add_vec("err_num0",     4,   1,  0,  0,   0,  1,   0,  0);
`endif
        add_vec("duty",         5,   3,  2,  0,   0,  0,  11,  1);
        add_vec("abort",        8,   4, 10,  6,   0,  0,   7,  0);
        add_vec("restart",      3,   2,  2,  0,   0,  0,   7,  1);
        add_vec("min_burst",    2,   1,  1,  0,   0,  0,   3,  0);
        add_vec("w_eq_p_m1",    6,   5,  2,  0,   0,  0,  13,  1);
        add_vec("start_busy",   4,   2,  2,  0,   1,  0,   9,  1);
        add_vec("max_period", 255, 254,  1,  0,   0,  0, 256,  0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        pop_check("reset", 0);
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start and stop together in IDLE, then stop alone: no activity at all.
        start_i = 1'b1;
        stop_i  = 1'b1;
        drive_cfg(4, 1, 3);
        for (int k = 1; k <= 3; k++) begin
            sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, last_idx));
            @(negedge clk);
            pop_check("start_stop_idle", k);
            start_i = 1'b0;
            stop_i  = (k == 1);
        end
        stop_i = 1'b0;

        // Reset in the middle of the second pulse: outputs drop next cycle, no done strobe.
        start_i = 1'b1;
        drive_cfg(2, 1, 3);
        sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0));
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0));
        sb.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 1));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        sb.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            pop_check("rst_mid_burst", k);
            start_i = 1'b0;
            rst     = (k == 3);
        end
        rst      = 1'b0;
        last_idx = 0;

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
